// File: rtl/npu_mem_port_if.sv
// Burst memory port bundle: request, write-beat and read-beat channels plus status pulses.
// The master drives requests and write beats; the slave is the memory port.
interface npu_mem_port_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16
);
    localparam int LEN_W = $clog2(MAX_BURST);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [LEN_W-1:0]      req_len;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  rdata_valid;
    logic [DATA_W-1:0]     rdata;
    logic                  rdata_last;
    logic                  wr_done;
    logic                  err;

    modport master (
        output req_valid, req_we, req_addr, req_len, wdata_valid, wdata, wstrb,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wdata_valid, wdata, wstrb,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, err
    );
endinterface

// File: rtl/npu_mem_port.sv
// Single-port burst memory with byte-strobed writes and an RD_LAT-deep read pipeline.
// Optional NPU_MEM_BOUNDS_CHECK_EN rejects bursts that would run past DEPTH instead of wrapping.
module npu_mem_port #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    npu_mem_port_if.slave    bus
);
    localparam int NB    = DATA_W / 8;
    localparam int SHIFT = $clog2(NB);
    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = $clog2(MAX_BURST);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

    state_t              state;
    logic [AW-1:0]       addr_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    cnt;
    logic                wr_done_q;
    logic                err_q;
    logic                reject;
    logic                rd_issue;
    logic                wr_fire;
    logic [AW-1:0]       start_word;
    logic [AW-1:0]       next_addr;

    logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

    logic [RD_LAT-1:0]   vld_p;
    logic [RD_LAT-1:0]   last_p;
    logic [DATA_W-1:0]   data_p [RD_LAT];

`ifdef NPU_MEM_BOUNDS_CHECK_EN
    assign reject = ({1'b0, bus.req_addr >> SHIFT} + (ADDR_W+1)'(bus.req_len))
                    >= (ADDR_W+1)'(DEPTH);
`else
    assign reject = 1'b0;
`endif

    assign start_word = AW'((bus.req_addr >> SHIFT) % ADDR_W'(DEPTH));
    assign next_addr  = (addr_r == AW'(DEPTH - 1)) ? '0 : addr_r + 1'b1;
    assign rd_issue   = (state == READ);
    assign wr_fire    = (state == WRITE) && bus.wdata_valid;

    assign bus.req_ready   = (state == IDLE);
    assign bus.wdata_ready = (state == WRITE);
    assign bus.wr_done     = wr_done_q;
    assign bus.err         = err_q;
    assign bus.rdata_valid = vld_p[RD_LAT-1];
    assign bus.rdata_last  = last_p[RD_LAT-1];
    assign bus.rdata       = data_p[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_r    <= '0;
            len_r     <= '0;
            cnt       <= '0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_r <= start_word;
                            len_r  <= bus.req_len;
                            cnt    <= '0;
                            state  <= bus.req_we ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    addr_r <= next_addr;
                    cnt    <= cnt + 1'b1;
                    if (cnt == len_r) state <= DRAIN;
                end
                WRITE: begin
                    if (bus.wdata_valid) begin
                        addr_r <= next_addr;
                        cnt    <= cnt + 1'b1;
                        if (cnt == len_r) begin
                            state     <= IDLE;
                            wr_done_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The final beat is on the output this cycle, so nothing is left in flight.
                    if (last_p[RD_LAT-1]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wstrb[b]) mem[addr_r][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
    end

    // Stage 0: array read; stages 1..RD_LAT-1: delay line to the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p  <= '0;
            last_p <= '0;
            for (int i = 0; i < RD_LAT; i++) data_p[i] <= '0;
        end else begin
            vld_p[0]  <= rd_issue;
            last_p[0] <= rd_issue && (cnt == len_r);
            data_p[0] <= rd_issue ? mem[addr_r] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end
endmodule

// File: tb/tb_npu_mem_port.sv
// Randomized bench for npu_mem_port against an array-based burst model, plus directed corner cases.
module tb_npu_mem_port;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 64;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 16;
    localparam int NB        = DATA_W / 8;
    localparam int LEN_W     = $clog2(MAX_BURST);
`ifdef NPU_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    npu_mem_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) bus ();

    npu_mem_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] wq_data [$];
    logic [NB-1:0]     wq_strb [$];
    logic [DATA_W-1:0] rd_got  [$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rejected(input int word, input int len);
        return BOUNDS && ((word + len) >= DEPTH);
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic start_req(input bit we, input int word, input int len);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = ADDR_W'(word * 4 + int'($urandom_range(0, 3)));
        bus.req_len   = LEN_W'(len);
        tick();
        bus.req_valid = 1'b0;
    endtask

    // gap < 0 selects a random 0..2 idle cycles before each beat
    task automatic do_write(input int word, input int len, input int gap);
        bit rej;
        wait_idle();
        rej = rejected(word, len);
        bus.wdata_valid = 1'b0;
        start_req(1'b1, word, len);
        chk("wr_err", 32'(bus.err), 32'(rej));
        if (rej) begin
            chk("wr_rej_idle", 32'(bus.req_ready), 32'd1);
            tick();
            chk("wr_err_once", 32'(bus.err), 32'd0);
            return;
        end
        for (int i = 0; i <= len; i++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                bus.wdata_valid = 1'b0;
                bus.wdata       = $urandom;
                tick();
                chk("wr_done_gap", 32'(bus.wr_done), 32'd0);
            end
            chk("wdata_ready", 32'(bus.wdata_ready), 32'd1);
            bus.wdata_valid = 1'b1;
            bus.wdata       = wq_data[i];
            bus.wstrb       = wq_strb[i];
            tick();
            bus.wdata_valid = 1'b0;
            for (int b = 0; b < NB; b++)
                if (wq_strb[i][b]) model_mem[(word + i) % DEPTH][b*8 +: 8] = wq_data[i][b*8 +: 8];
            if (i < len) chk("wr_done_early", 32'(bus.wr_done), 32'd0);
        end
        chk("wr_done", 32'(bus.wr_done), 32'd1);
        chk("wr_idle", 32'(bus.req_ready), 32'd1);
        tick();
        chk("wr_done_once", 32'(bus.wr_done), 32'd0);
    endtask

    task automatic do_read(input int word, input int len);
        bit rej;
        bit exp_v;
        int kf;
        int kmax;
        int beat = 0;
        wait_idle();
        rej = rejected(word, len);
        rd_got.delete();
        start_req(1'b0, word, len);
        chk("rd_err", 32'(bus.err), 32'(rej));
        kf   = RD_LAT + 1 + len;
        kmax = rej ? kf + 2 : kf + 1;
        for (int k = 1; k <= kmax; k++) begin
            if (k > 1) tick();
            bus.wdata_valid = 1'($urandom_range(0, 1));
            bus.wdata       = $urandom;
            bus.wstrb       = NB'($urandom);
            exp_v = !rej && (k >= RD_LAT + 1) && (k <= kf);
            chk("rd_valid", 32'(bus.rdata_valid), 32'(exp_v));
            if (exp_v) begin
                rd_got.push_back(bus.rdata);
                chk("rd_data", bus.rdata, model_mem[(word + beat) % DEPTH]);
                chk("rd_last", 32'(bus.rdata_last), 32'(k == kf));
                beat++;
            end
            if (rej) chk("rd_rej_idle", 32'(bus.req_ready), 32'd1);
            else if (k >= kf) chk("rd_ready", 32'(bus.req_ready), 32'(k > kf));
        end
        bus.wdata_valid = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_rvalid"}, 32'(bus.rdata_valid), 32'd0);
        chk({tag, "_rdata"},  bus.rdata, 32'd0);
        chk({tag, "_rlast"},  32'(bus.rdata_last), 32'd0);
        chk({tag, "_wready"}, 32'(bus.wdata_ready), 32'd0);
        chk({tag, "_wrdone"}, 32'(bus.wr_done), 32'd0);
        chk({tag, "_err"},    32'(bus.err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        foreach (model_mem[i]) model_mem[i] = '0;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.wstrb       = '0;
        rst = 1'b1;
        #1;
        check_quiet("rst");
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(bus.req_ready), 32'd1);
        tick();

        wq_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4, 3, 0);
        do_read(4, 3);
        for (int i = 0; i < 4; i++) chk("burst_a0", rd_got[i], 32'hA0 + 32'(i));

        wq_data = '{32'hDEADBEEF};
        wq_strb = '{4'h0};
        do_write(4, 0, 0);
        do_read(4, 0);
        chk("strb0_keep", rd_got[0], 32'hA0);

        wq_data = '{32'h11223344};
        wq_strb = '{4'hF};
        do_write(0, 0, 0);
        wq_data = '{32'hFFFFFFFF};
        wq_strb = '{4'h2};
        do_write(0, 0, 0);
        do_read(0, 0);
        chk("byte_lane", rd_got[0], 32'h1122FF44);

        wq_data = '{32'h55, 32'h66};
        wq_strb = '{4'hF, 4'hF};
        do_write(8, 1, 2);
        do_read(8, 3);

        wq_data = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(DEPTH - 2, 3, 0);
        do_read(DEPTH - 2, 3);
        if (!BOUNDS) chk("wrap_word0", rd_got[2], 32'hC2);

        // Reset lands while the second of eight read beats is on the output.
        wait_idle();
        start_req(1'b0, 16, 7);
        repeat (3) tick();
        chk("rst_mid_beat2", 32'(bus.rdata_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_quiet("rst_mid");
        tick();
        tick();
        check_quiet("rst_hold");
        rst = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_no_beats", 32'(bus.rdata_valid), 32'd0);
        end
        do_read(4, 3);

        for (int n = 0; n < 60; n++) begin
            int word;
            int len;
            word = int'($urandom_range(0, DEPTH - 1));
            len  = int'($urandom_range(0, MAX_BURST - 1));
            if ($urandom_range(0, 1) == 1) begin
                wq_data.delete();
                wq_strb.delete();
                for (int i = 0; i <= len; i++) begin
                    wq_data.push_back($urandom);
                    wq_strb.push_back(($urandom_range(0, 7) == 0) ? NB'(0) : NB'($urandom_range(1, 15)));
                end
                do_write(word, len, -1);
            end else begin
                do_read(word, len);
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.wdata_valid = 1'b1;
                bus.wdata       = $urandom;
                bus.wstrb       = NB'($urandom);
                tick();
                bus.wdata_valid = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/npu_mem_port.md
NPU_MEM_PORT -- requirements
Module: npu_mem_port

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
 DATA_W, 32, data word width in bits; multiple of 8.
 ADDR_W, 32, byte-address width.
 DEPTH, 1024, number of DATA_W words in the internal array.
 RD_LAT, 2, read latency in cycles, legal 1..4.
 MAX_BURST, 16, maximum beats per burst; power of two.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  single clock; all logic on rising edge.
 rst  in  1  asynchronous, active-high reset.
 req_valid  in  1  burst request valid.
 req_ready  out  1  burst request accepted when high with req_valid.
 req_we  in  1  1 = write burst, 0 = read burst.
 req_addr  in  ADDR_W  byte start address; low log2(DATA_W/8) bits ignored.
 req_len  in  log2(MAX_BURST)  beats minus one.
 wdata_valid  in  1  write beat valid.
 wdata_ready  out  1  write beat accepted when high with wdata_valid.
 wdata  in  DATA_W  write data.
 wstrb  in  DATA_W/8  byte-lane enables.
 rdata_valid  out  1  read beat valid; sink always ready.
 rdata  out  DATA_W  read data.
 rdata_last  out  1  final beat of a read burst.
 wr_done  out  1  one-cycle pulse after final write beat.
 err  out  1  one-cycle pulse on rejected request.

Function
REQ-003 FSM SHALL have states IDLE, READ, WRITE, DRAIN; req_ready SHALL be high only in IDLE.
REQ-004 On req_valid&&req_ready the block SHALL latch word address (req_addr >> log2(DATA_W/8)), req_len, req_we, then enter READ or WRITE next cycle.
REQ-005 In READ the block SHALL issue one array read per cycle at consecutive word addresses, len+1 issues, then enter DRAIN.
REQ-006 Each read issued in cycle N SHALL appear as rdata_valid with data in cycle N+RD_LAT via an RD_LAT-deep valid/data/last pipeline.
REQ-007 rdata_last SHALL be high only together with the final beat's rdata_valid.
REQ-008 DRAIN SHALL return to IDLE in the cycle after the final beat's rdata_valid is no longer pending in the pipeline; no new request is accepted before that.
REQ-009 In WRITE wdata_ready SHALL be high; each wdata handshake SHALL update only byte lanes with wstrb bit set, then advance the address.
REQ-010 After handshake of beat len+1, wr_done SHALL pulse the next cycle and the FSM SHALL be in IDLE that same cycle.
REQ-011 A write committed on a clock edge SHALL be visible to any read issued on or after the following cycle.
REQ-012 wdata_valid outside WRITE SHALL be ignored; wstrb == 0 SHALL consume a beat without modifying memory.
REQ-013 Word address arithmetic SHALL be modulo DEPTH unless bounds checking is compiled in (REQ-017).
REQ-014 Array contents SHALL initialise to zero at time zero and are not affected by rst.

Reset
REQ-015 Asserting rst SHALL immediately force IDLE, clear the read pipeline, and drive req_ready=1 (after release), wdata_ready=0, rdata_valid=0, rdata=0, rdata_last=0, wr_done=0, err=0.
REQ-016 Reset mid-burst SHALL abandon remaining beats; beats already committed remain in memory; in-flight read beats are never delivered.

Configuration
REQ-017 Macro NPU_MEM_BOUNDS_CHECK_EN: when defined, a request with start word + len >= DEPTH SHALL be rejected: err pulses the cycle after handshake, FSM stays IDLE, memory untouched, no rdata/wr_done; when undefined, err is tied 0 and addresses wrap modulo DEPTH.

Verification
REQ-018 Write burst addr 0x10, len 3, wdata 0xA0..0xA3, wstrb 0xF -> wr_done pulses once; words 4..7 = 0xA0..0xA3.
REQ-019 Read burst addr 0x10, len 3, RD_LAT=2 -> rdata_valid 4 consecutive cycles starting 3 cycles after handshake, data 0xA0..0xA3, rdata_last on 4th only.
REQ-020 Write word 0 = 0x11223344 then single write wstrb 0x2 data 0xFFFFFFFF -> read returns 0x1122FF44.
REQ-021 Bounds check: with macro, read addr (DEPTH-2)*4 len 3 -> err pulse, no rdata_valid; without macro -> beats from words DEPTH-2, DEPTH-1, 0, 1.
REQ-022 Assert rst during beat 2 of a len-7 read -> rdata_valid low from reset onward, req_ready high first cycle after release.
REQ-023 Write beats with wdata_valid gaps of 2 idle cycles, len 1 -> exactly 2 writes, wr_done after second handshake.
